// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan scheduler:
// bus constants, phase encoding and common/brightness helpers.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;

  typedef enum logic [1:0] {
    BLANK,
    SHOW,
    DARK
  } phase_t;

  // Digit 0 owns the MSB of the common vector; bits above num_digits stay high.
  function automatic logic [7:0] com_onehot_n(input int unsigned index,
                                              input int unsigned num_digits);
    logic [7:0] v;
    v = '1;
    v[3'(num_digits - 1 - index)] = 1'b0;
    return v;
  endfunction

  // ((bright + 1) * w) >> 4, evaluated in 64 bits, clamped to at least 1.
  function automatic int unsigned on_cycles_calc(input logic [3:0] bright,
                                                 input int unsigned w);
    logic [63:0] prod;
    prod = (64'(bright) + 64'd1) * 64'(w);
    prod = prod >> 4;
    return (prod == 64'd0) ? 32'd1 : 32'(prod);
  endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Digit-pattern inputs and display-side outputs of the scan scheduler.
interface seg_scan_scheduler_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic [8*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              bright;
  logic [NUM_DIGITS-1:0]   seg_com;
  logic [7:0]              seg_data;
  logic                    frame_done;

  modport master (
    output digit_data, digit_en, bright,
    input  seg_com, seg_data, frame_done
  );

  modport slave (
    input  digit_data, digit_en, bright,
    output seg_com, seg_data, frame_done
  );

endinterface

// File: rtl/scan_slot_timer.sv
// Slot cycle counter and digit index for the scan scheduler, with wrap
// logic and slot/frame start strobes decoded from the counter state.
module scan_slot_timer #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SLOT_CYCLES = 1000,
  parameter int unsigned KW          = $clog2(SLOT_CYCLES),
  parameter int unsigned IW          = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [KW-1:0] k,
  output logic [IW-1:0] index,
  output logic          slot_start,
  output logic          frame_start
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      index <= '0;
    end else if (k == KW'(SLOT_CYCLES - 1)) begin
      k     <= '0;
      index <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
    end else begin
      k <= k + 1'b1;
    end
  end

  assign slot_start  = (k == '0);
  assign frame_start = slot_start && (index == '0);

endmodule

// File: rtl/seg_scan_scheduler.sv
// Time-multiplexes one segment bus across NUM_DIGITS active-low-common
// digits: per slot a blanking gap, then a brightness-scaled on-window.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  seg_scan_scheduler_if.slave bus
);

  localparam int unsigned W  = SLOT_CYCLES - BLANK_CYCLES;
  localparam int unsigned KW = $clog2(SLOT_CYCLES);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [KW-1:0] k;
  logic [IW-1:0] index;
  logic          slot_start;
  logic          frame_start;

  scan_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SLOT_CYCLES(SLOT_CYCLES),
    .KW         (KW),
    .IW         (IW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .k          (k),
    .index      (index),
    .slot_start (slot_start),
    .frame_start(frame_start)
  );

  logic [KW-1:0] on_cycles;
  logic [7:0]    snap_data;
  logic          snap_en;
  logic [31:0]   kx;
  logic          in_blank;
  logic          in_window;

  assign kx        = 32'(k);
  assign in_blank  = slot_start || (kx < BLANK_CYCLES);
  assign in_window = kx < (BLANK_CYCLES + 32'(on_cycles));

  // Brightness is latched only at frame start; the digit snapshot is taken
  // on the last blanking cycle so the whole on-window shows one pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_cycles <= KW'(W);
      snap_data <= SEG_OFF;
      snap_en   <= 1'b0;
    end else begin
      if (frame_start)
        on_cycles <= KW'(on_cycles_calc(bus.bright, W));
      if (kx == BLANK_CYCLES - 1) begin
        snap_data <= bus.digit_data[{index, 3'b000} +: 8];
        snap_en   <= bus.digit_en[index];
      end
    end
  end

  phase_t                phase;
  logic [NUM_DIGITS-1:0] seg_com_q;
  logic [7:0]            seg_data_q;
  logic                  frame_done_q;

  // phase holds the phase of the previous slot cycle; k selects the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= BLANK;
      seg_com_q    <= '1;
      seg_data_q   <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (kx == SLOT_CYCLES - 1) && (32'(index) == NUM_DIGITS - 1);
      case (phase)
        BLANK: begin
          if (in_blank) begin
            phase      <= BLANK;
            seg_com_q  <= '1;
            seg_data_q <= SEG_OFF;
          end else if (in_window && snap_en) begin
            phase      <= SHOW;
            seg_com_q  <= NUM_DIGITS'(com_onehot_n(32'(index), NUM_DIGITS));
            seg_data_q <= snap_data;
          end else begin
            phase      <= DARK;
            seg_com_q  <= '1;
            seg_data_q <= SEG_OFF;
          end
        end
        SHOW: begin
          if (in_blank) begin
            phase      <= BLANK;
            seg_com_q  <= '1;
            seg_data_q <= SEG_OFF;
          end else if (in_window) begin
            phase      <= SHOW;
            seg_com_q  <= NUM_DIGITS'(com_onehot_n(32'(index), NUM_DIGITS));
            seg_data_q <= snap_data;
          end else begin
            phase      <= DARK;
            seg_com_q  <= '1;
            seg_data_q <= SEG_OFF;
          end
        end
        default: begin
          phase      <= in_blank ? BLANK : DARK;
          seg_com_q  <= '1;
          seg_data_q <= SEG_OFF;
        end
      endcase
    end
  end

  assign bus.seg_com    = seg_com_q;
  assign bus.seg_data   = seg_data_q;
  assign bus.frame_done = frame_done_q;

endmodule
